// File: rtl/reg_bank_master.sv
// Valid/ready front-end that sequences reg_bank's en/rnw/addr/shared data bus.
// Define REG_BANK_MASTER_READBACK_EN to read back and compare every write.
module reg_bank_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4,
  parameter int SYNC_READ  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rnw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  en,
  output logic                  rnw,
  output logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data
);

  typedef enum logic [2:0] {IDLE, WR, TURN, RD, RSP} state_e;

  // Index of the final RD cycle: a registered bank needs one extra cycle.
  localparam logic RD_LAST = (SYNC_READ != 0);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  cnt_q, cnt_d;
`ifdef REG_BANK_MASTER_READBACK_EN
  logic                  rnw_q, rnw_d;
  logic                  err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
`ifdef REG_BANK_MASTER_READBACK_EN
    rnw_d   = rnw_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 1'b0;
`ifdef REG_BANK_MASTER_READBACK_EN
          rnw_d   = req_rnw;
`endif
          state_d = req_rnw ? RD : WR;
        end
      end
      WR: begin
`ifdef REG_BANK_MASTER_READBACK_EN
        state_d = TURN;
`else
        rdata_d = wdata_q;
        state_d = RSP;
`endif
      end
      TURN: begin
        cnt_d   = 1'b0;
        state_d = RD;
      end
      RD: begin
        if (cnt_q == RD_LAST) begin
          rdata_d = data;
`ifdef REG_BANK_MASTER_READBACK_EN
          err_d   = !rnw_q && (data != wdata_q);
`endif
          state_d = RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 1'b0;
`ifdef REG_BANK_MASTER_READBACK_EN
      rnw_q   <= 1'b1;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
`ifdef REG_BANK_MASTER_READBACK_EN
      rnw_q   <= rnw_d;
      err_q   <= err_d;
`endif
    end
  end

  // req_ready is masked by rst so nothing looks acceptable while reset is held.
  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RSP);
  assign rsp_rdata = rdata_q;
  assign en        = (state_q == WR) || (state_q == RD);
  assign rnw       = (state_q != WR);
  assign addr      = addr_q;
  assign data      = (state_q == WR) ? wdata_q : {DATA_WIDTH{1'bz}};

`ifdef REG_BANK_MASTER_READBACK_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bank_master.sv
// Directed bench for reg_bank_master with behavioural banks: instance A uses a
// registered-read bank, instance B a combinational one.
module tb_reg_bank_master;

  localparam logic [3:0] PROBE = 4'h6;
`ifdef REG_BANK_MASTER_READBACK_EN
  localparam int WR_LAT_A = 5;
  localparam int WR_LAT_B = 4;
`else
  localparam int WR_LAT_A = 2;
  localparam int WR_LAT_B = 2;
`endif
  localparam int RD_LAT_A = 3;
  localparam int RD_LAT_B = 2;

  logic       clk = 1'b0;
  logic       rst, bankClear;
  logic       reqValidA, reqValidB, reqRnw, rspReady;
  logic [3:0] reqAddr, reqWdata, corruptMask;

  logic       reqReadyA, rspValidA, rspErrA, enA, rnwA;
  logic [3:0] rspRdataA, addrA;
  wire  [3:0] busA;
  logic       reqReadyB, rspValidB, rspErrB, enB, rnwB;
  logic [3:0] rspRdataB, addrB;
  wire  [3:0] busB;

  int vectorCount = 0;
  int missCount = 0;
  int sawValid;

  always #5 clk = ~clk;

  reg_bank_master #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .SYNC_READ(1)) dutA (
    .clk(clk), .rst(rst),
    .req_valid(reqValidA), .req_ready(reqReadyA), .req_rnw(reqRnw),
    .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rspValidA), .rsp_ready(rspReady), .rsp_rdata(rspRdataA), .rsp_err(rspErrA),
    .en(enA), .rnw(rnwA), .addr(addrA), .data(busA)
  );

  reg_bank_master #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .SYNC_READ(0)) dutB (
    .clk(clk), .rst(rst),
    .req_valid(reqValidB), .req_ready(reqReadyB), .req_rnw(reqRnw),
    .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rspValidB), .rsp_ready(rspReady), .rsp_rdata(rspRdataB), .rsp_err(rspErrB),
    .en(enB), .rnw(rnwB), .addr(addrB), .data(busB)
  );

  // Bank A: registered read; bench drives PROBE whenever en is low so a
  // master that fails to release the bus shows up as a wrong bus value.
  logic [3:0] memA [16];
  logic [3:0] rdQA;
  logic       rdVA;
  always @(posedge clk) begin
    if (bankClear) begin
      for (int i = 0; i < 16; i++) memA[i] <= '0;
      rdQA <= '0;
      rdVA <= 1'b0;
    end else begin
      if (enA && !rnwA) memA[addrA] <= busA;
      rdVA <= enA && rnwA;
      rdQA <= memA[addrA] ^ corruptMask;
    end
  end
  assign busA = !enA ? PROBE : 4'bz;
  assign busA = (enA && rnwA && rdVA) ? rdQA : 4'bz;

  // Bank B: combinational read.
  logic [3:0] memB [16];
  always @(posedge clk) begin
    if (bankClear) begin
      for (int i = 0; i < 16; i++) memB[i] <= '0;
    end else if (enB && !rnwB) begin
      memB[addrB] <= busB;
    end
  end
  assign busB = !enB ? PROBE : 4'bz;
  assign busB = (enB && rnwB) ? memB[addrB] : 4'bz;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one request at a negedge; returns 1 time unit after the accept edge.
  task automatic applyStimulus(input bit sel, input logic r, input logic [3:0] a,
                               input logic [3:0] w, input string tag);
    @(negedge clk);
    reqRnw   = r;
    reqAddr  = a;
    reqWdata = w;
    if (sel) reqValidB = 1'b1; else reqValidA = 1'b1;
    checkOutput({tag, "_req_ready"}, 32'(sel ? reqReadyB : reqReadyA), 1);
    @(posedge clk);
    #1;
    reqValidA = 1'b0;
    reqValidB = 1'b0;
  endtask

  // expEdge counts edges after the current one up to the first edge that samples rsp_valid high.
  task automatic waitRsp(input bit sel, input int expEdge, input string tag);
    int offset = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sel ? rspValidB : rspValidA) begin
        offset = i + 1;
        break;
      end
      @(posedge clk);
    end
    checkOutput({tag, "_latency"}, offset, expEdge);
  endtask

  task automatic finishRsp(input bit sel, input string tag);
    rspReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_rsp_done"}, 32'(sel ? rspValidB : rspValidA), 0);
    checkOutput({tag, "_req_ready_back"}, 32'(sel ? reqReadyB : reqReadyA), 1);
  endtask

  task automatic doTxn(input bit sel, input logic r, input logic [3:0] a, input logic [3:0] w,
                       input int lat, input logic [3:0] expData, input logic expErr, input string tag);
    applyStimulus(sel, r, a, w, tag);
    waitRsp(sel, lat, tag);
    checkOutput({tag, "_rdata"}, 32'(sel ? rspRdataB : rspRdataA), 32'(expData));
    checkOutput({tag, "_err"}, 32'(sel ? rspErrB : rspErrA), 32'(expErr));
    finishRsp(sel, tag);
  endtask

  initial begin
    rst = 1'b1; bankClear = 1'b1; corruptMask = 4'h0; rspReady = 1'b1;
    reqValidA = 1'b1; reqValidB = 1'b1; reqRnw = 1'b0; reqAddr = 4'h1; reqWdata = 4'h1;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_req_ready", 32'(reqReadyA), 0);
      checkOutput("rst_en", 32'(enA), 0);
      checkOutput("rst_bus", 32'(busA), 32'(PROBE));
      checkOutput("rst_rsp_valid", 32'(rspValidA), 0);
    end
    checkOutput("rst_rnw", 32'(rnwA), 1);
    checkOutput("rst_addr", 32'(addrA), 0);
    checkOutput("rst_rdata", 32'(rspRdataA), 0);
    checkOutput("rst_err", 32'(rspErrA), 0);
    rst = 1'b0; bankClear = 1'b0; reqValidA = 1'b0; reqValidB = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst_req_ready", 32'(reqReadyA), 1);

    doTxn(0, 1'b0, 4'h5, 4'hA, WR_LAT_A, 4'hA, 1'b0, "wr5");
    doTxn(0, 1'b1, 4'h5, 4'h0, RD_LAT_A, 4'hA, 1'b0, "rd5");

    // Response stall with a competing write held on the request port.
    rspReady = 1'b0;
    applyStimulus(0, 1'b1, 4'h5, 4'h0, "bp");
    waitRsp(0, RD_LAT_A, "bp");
    reqValidA = 1'b1; reqRnw = 1'b0; reqAddr = 4'h5; reqWdata = 4'h0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", 32'(rspValidA), 1);
      checkOutput("bp_rdata", 32'(rspRdataA), 'hA);
      checkOutput("bp_req_ready", 32'(reqReadyA), 0);
      checkOutput("bp_en", 32'(enA), 0);
      checkOutput("bp_bus", 32'(busA), 32'(PROBE));
      @(posedge clk);
      @(negedge clk);
    end
    reqValidA = 1'b0;
    finishRsp(0, "bp");

    doTxn(0, 1'b0, 4'hF, 4'h3, WR_LAT_A, 4'h3, 1'b0, "wrF_3");
    doTxn(0, 1'b0, 4'hF, 4'hC, WR_LAT_A, 4'hC, 1'b0, "wrF_C");
    doTxn(0, 1'b1, 4'hF, 4'h0, RD_LAT_A, 4'hC, 1'b0, "rdF");
    doTxn(0, 1'b1, 4'h0, 4'h0, RD_LAT_A, 4'h0, 1'b0, "rd0");
    doTxn(0, 1'b1, 4'h5, 4'h0, RD_LAT_A, 4'hA, 1'b0, "rd5_kept");

    applyStimulus(0, 1'b0, 4'h2, 4'h7, "wr2");
    @(negedge clk);
    checkOutput("wr2_en", 32'(enA), 1);
    checkOutput("wr2_rnw", 32'(rnwA), 0);
    checkOutput("wr2_addr", 32'(addrA), 'h2);
    checkOutput("wr2_bus", 32'(busA), 'h7);
    @(posedge clk);
`ifdef REG_BANK_MASTER_READBACK_EN
    @(negedge clk);
    checkOutput("turn_en", 32'(enA), 0);
    checkOutput("turn_bus", 32'(busA), 32'(PROBE));
    @(posedge clk);
    waitRsp(0, 3, "wr2");
`else
    waitRsp(0, 1, "wr2");
`endif
    checkOutput("wr2_rdata", 32'(rspRdataA), 'h7);
    checkOutput("wr2_err", 32'(rspErrA), 0);
    finishRsp(0, "wr2");

`ifdef REG_BANK_MASTER_READBACK_EN
    corruptMask = 4'h1;
    doTxn(0, 1'b0, 4'h3, 4'h9, WR_LAT_A, 4'h8, 1'b1, "wr3_corrupt");
    corruptMask = 4'h0;
    doTxn(0, 1'b1, 4'h2, 4'h0, RD_LAT_A, 4'h7, 1'b0, "rd2_after_err");
`endif

    // Reset while the read is in its first RD cycle.
    applyStimulus(0, 1'b1, 4'hF, 4'h0, "abort");
    @(negedge clk);
    checkOutput("abort_en_rd", 32'(enA), 1);
    checkOutput("abort_rnw_rd", 32'(rnwA), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_en", 32'(enA), 0);
    checkOutput("abort_addr", 32'(addrA), 0);
    checkOutput("abort_rdata", 32'(rspRdataA), 0);
    checkOutput("abort_req_ready", 32'(reqReadyA), 0);
    sawValid = int'(rspValidA);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rspValidA) sawValid = 1;
    end
    checkOutput("abort_no_rsp", sawValid, 0);
    checkOutput("abort_req_ready_back", 32'(reqReadyA), 1);
    doTxn(0, 1'b1, 4'hF, 4'h0, RD_LAT_A, 4'hC, 1'b0, "rdF_after_abort");

    doTxn(1, 1'b0, 4'h5, 4'hA, WR_LAT_B, 4'hA, 1'b0, "b_wr5");
    doTxn(1, 1'b1, 4'h5, 4'h0, RD_LAT_B, 4'hA, 1'b0, "b_rd5");
    doTxn(1, 1'b1, 4'h9, 4'h0, RD_LAT_B, 4'h0, 1'b0, "b_rd9");

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
